// File: rtl/thermal_link_ctrl.sv
// rtl/thermal_link_ctrl.sv - thermal covert-channel transceiver: OOK heater transmitter plus ring-oscillator edge counter
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   enable                     transmitter enable; dropping it mid-frame aborts the frame
//   tx_data, tx_valid,         payload handshake; tx_data is captured when tx_valid && tx_ready
//   tx_ready
//   busy                       a frame (preamble, data or guard) is in progress
//   heat_on                    bit currently being keyed (1 = heating)
//   heater                     NUM_BANKS*HEATER_W toggle flops; they toggle while heat_on is high
//   ro_in                      asynchronous ring-oscillator sense input
//   meas_count, meas_valid     edge count of the last completed window, with a one-cycle update strobe
//   leds                       meas_count shown one byte at a time, LSB byte first
module thermal_link_ctrl #(
    parameter int NUM_BANKS  = 4,
    parameter int HEATER_W   = 75,
    parameter int DATA_W     = 8,
    parameter int BIT_PERIOD = 1000000,
    parameter int WINDOW     = 65536,
    parameter int CNT_W      = 20,
    parameter int DISP_SHIFT = 17
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          busy,
    output logic                          heat_on,
    output logic [NUM_BANKS*HEATER_W-1:0] heater,
    input  logic                          ro_in,
    output logic [CNT_W-1:0]              meas_count,
    output logic                          meas_valid,
    output logic [7:0]                    leds
);

    localparam int PER_W  = $clog2(BIT_PERIOD);
    localparam int WIN_W  = $clog2(WINDOW);
    localparam int NB     = (CNT_W + 7) / 8;
    localparam int SLOT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int TMR_W  = DISP_SHIFT + SLOT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_GUARD
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [PER_W-1:0]      per_cnt_q;
    logic [4:0]            bit_idx_q;
    logic [DATA_W-1:0]     shift_q;
    logic [DATA_W-1:0]     shift_nxt;
    logic                  heat_on_q;
    logic                  per_tc;

    (* keep = "true" *) logic [NUM_BANKS*HEATER_W-1:0] heater_q;

    assign per_tc    = (per_cnt_q == PER_W'(BIT_PERIOD - 1));
    assign shift_nxt = shift_q >> 1;

    // Gating with reset keeps tx_ready low while reset is held, even with enable high.
    assign tx_ready = enable && (state_q == S_IDLE) && !reset;
    assign busy     = (state_q != S_IDLE);
    assign heat_on  = heat_on_q;
    assign heater   = heater_q;

    // heat_on_q is loaded with the value of the bit about to start, so the
    // keyed bit appears on heat_on in the same cycle the FSM enters it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            per_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            heat_on_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        state_q   <= S_PREAMBLE;
                        per_cnt_q <= '0;
                        bit_idx_q <= '0;
                        shift_q   <= tx_data;
                        heat_on_q <= 1'b1;           // preamble MSB
                    end
                end
                default: begin
                    if (!enable) begin
                        state_q   <= S_IDLE;
                        per_cnt_q <= '0;
                        heat_on_q <= 1'b0;
                    end else if (per_tc) begin
                        per_cnt_q <= '0;
                        case (state_q)
                            S_PREAMBLE: begin
                                if (bit_idx_q == 5'd7) begin
                                    state_q   <= S_DATA;
                                    bit_idx_q <= '0;
                                    heat_on_q <= shift_q[0];
                                end else begin
                                    bit_idx_q <= bit_idx_q + 5'd1;
                                    // 10101010: the next bit is 1 exactly when the next index is even
                                    heat_on_q <= bit_idx_q[0];
                                end
                            end
                            S_DATA: begin
                                if (bit_idx_q == 5'(DATA_W - 1)) begin
                                    state_q   <= S_GUARD;
                                    heat_on_q <= 1'b0;
                                end else begin
                                    bit_idx_q <= bit_idx_q + 5'd1;
                                    shift_q   <= shift_nxt;
                                    heat_on_q <= shift_nxt[0];
                                end
                            end
                            default: begin
                                state_q   <= S_IDLE;
                                heat_on_q <= 1'b0;
                            end
                        endcase
                    end else begin
                        per_cnt_q <= per_cnt_q + PER_W'(1);
                    end
                end
            endcase
        end
    end

    // All banks start from zero and invert together, so they stay in phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            heater_q <= '0;
        end else if (heat_on_q) begin
            heater_q <= ~heater_q;
        end else begin
            heater_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Measurement
    // ------------------------------------------------------------------
    logic              ro_s1_q, ro_s2_q, ro_prev_q;
    logic              ro_edge;
    logic [WIN_W-1:0]  win_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic [CNT_W-1:0]  edge_sum;
    logic [CNT_W-1:0]  meas_count_q;
    logic              meas_valid_q;
    logic              win_tc;

    assign ro_edge  = ro_s2_q && !ro_prev_q;
    assign win_tc   = (win_cnt_q == WIN_W'(WINDOW - 1));
    // Saturating total including an edge seen this cycle.
    assign edge_sum = (ro_edge && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;

    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ro_s1_q   <= 1'b0;
            ro_s2_q   <= 1'b0;
            ro_prev_q <= 1'b0;
        end else begin
            ro_s1_q   <= ro_in;
            ro_s2_q   <= ro_s1_q;
            ro_prev_q <= ro_s2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
        end else if (win_tc) begin
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            meas_count_q <= edge_sum;
            meas_valid_q <= 1'b1;
        end else begin
            win_cnt_q    <= win_cnt_q + WIN_W'(1);
            edge_cnt_q   <= edge_sum;
            meas_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // LED display
    // ------------------------------------------------------------------
    logic [TMR_W-1:0]  timer_q;
    logic [SLOT_W-1:0] slot;
    logic [NB*8-1:0]   disp_word;
    logic [7:0]        led_d;
    logic [7:0]        leds_q;

    assign slot = timer_q[TMR_W-1 -: SLOT_W];
    assign leds = leds_q;

    always_comb begin
        disp_word              = '0;
        disp_word[CNT_W-1:0]   = meas_count_q;
        led_d                  = 8'h00;   // slots past the last byte stay dark
        for (int i = 0; i < NB; i++) begin
            if (slot == SLOT_W'(i)) begin
                led_d = disp_word[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            leds_q  <= 8'h00;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
            leds_q  <= led_d;
        end
    end

endmodule

// File: tb/tb_thermal_link_ctrl.sv
// tb/tb_thermal_link_ctrl.sv - self-checking bench for thermal_link_ctrl
module tb_thermal_link_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ro_a = 1'b0;
    logic       ro_b = 1'b0;

    logic        tx_ready_a, busy_a, heat_on_a, meas_valid_a;
    logic [5:0]  heater_a;
    logic [19:0] meas_count_a;
    logic [7:0]  leds_a;

    logic        tx_ready_b, busy_b, heat_on_b, meas_valid_b;
    logic [1:0]  heater_b;
    logic [8:0]  meas_count_b;
    logic [7:0]  leds_b;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    initial begin #3; forever #20 ro_a = ~ro_a; end
    initial begin #3; forever #10 ro_b = ~ro_b; end

    thermal_link_ctrl #(
        .NUM_BANKS(2), .HEATER_W(3), .DATA_W(8), .BIT_PERIOD(4),
        .WINDOW(16), .CNT_W(20), .DISP_SHIFT(2)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready_a), .busy(busy_a),
        .heat_on(heat_on_a), .heater(heater_a), .ro_in(ro_a),
        .meas_count(meas_count_a), .meas_valid(meas_valid_a), .leds(leds_a)
    );

    thermal_link_ctrl #(
        .NUM_BANKS(1), .HEATER_W(2), .DATA_W(8), .BIT_PERIOD(4),
        .WINDOW(1024), .CNT_W(9), .DISP_SHIFT(2)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(1'b0), .tx_data(8'h00),
        .tx_valid(1'b0), .tx_ready(tx_ready_b), .busy(busy_b),
        .heat_on(heat_on_b), .heater(heater_b), .ro_in(ro_b),
        .meas_count(meas_count_b), .meas_valid(meas_valid_b), .leds(leds_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [16:0] bits;       // keyed bits in send order, first bit in [16]
        bit          hold_next;  // raise tx_valid with the next frame's data mid-frame
    } frame_t;

    frame_t frames [4];

    // Heater image over the first six cycles of a frame (preamble 1 then 0)
    logic [5:0] heater_exp [6] = '{6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00, 6'h00};

    // Entered just after a negedge; returns just after the negedge of cycle 69.
    task automatic send_frame(input int idx);
        logic [16:0] bits;
        bits     = frames[idx].bits;
        tx_data  = frames[idx].data;
        tx_valid = 1'b1;
        chk($sformatf("f%0d_ready_pre", idx), tx_ready_a, 1'b1);
        @(posedge clk);
        for (int cyc = 1; cyc <= 68; cyc++) begin
            @(negedge clk);
            if (cyc == 1) tx_valid = 1'b0;
            if (cyc == 5 && frames[idx].hold_next) begin
                tx_valid = 1'b1;
                tx_data  = frames[idx + 1].data;
            end
            chk($sformatf("f%0d_c%0d_heat_on", idx, cyc), heat_on_a, bits[16 - (cyc - 1) / 4]);
            chk($sformatf("f%0d_c%0d_busy", idx, cyc), busy_a, 1'b1);
            chk($sformatf("f%0d_c%0d_tx_ready", idx, cyc), tx_ready_a, 1'b0);
            if (cyc <= 6)
                chk($sformatf("f%0d_c%0d_heater", idx, cyc), heater_a, heater_exp[cyc - 1]);
        end
        @(negedge clk);
        chk($sformatf("f%0d_ready_c69", idx), tx_ready_a, 1'b1);
        chk($sformatf("f%0d_busy_c69", idx), busy_a, 1'b0);
    endtask

    initial begin
        int  n;
        bit  found;
        logic [7:0] prev;

        frames[0] = '{8'hA5, 17'b10101010_10100101_0, 1'b1};
        frames[1] = '{8'h3C, 17'b10101010_00111100_0, 1'b0};
        frames[2] = '{8'hFF, 17'b10101010_11111111_0, 1'b0};
        frames[3] = '{8'h01, 17'b10101010_10000000_0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        enable = 1'b1;
        #1;
        chk("rst_tx_ready", tx_ready_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_heat_on", heat_on_a, 1'b0);
        chk("rst_heater", heater_a, 6'h00);
        chk("rst_meas_count", meas_count_a, 20'h0);
        chk("rst_meas_valid", meas_valid_a, 1'b0);
        chk("rst_leds", leds_a, 8'h00);
        chk("rst_meas_count_b", meas_count_b, 9'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", tx_ready_a, 1'b1);

        // Frame table: back-to-back frames, first one holds tx_valid for the next while busy
        for (int i = 0; i < 4; i++) send_frame(i);
        tx_valid = 1'b0;

        // Abort by dropping enable at cycle 10
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        chk("abort_ready_pre", tx_ready_a, 1'b1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_c10_busy", busy_a, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_c11_busy", busy_a, 1'b0);
        chk("abort_c11_heat_on", heat_on_a, 1'b0);
        chk("abort_c11_tx_ready", tx_ready_a, 1'b0);
        @(negedge clk);
        chk("abort_c12_heater", heater_a, 6'h00);
        chk("abort_c12_tx_ready", tx_ready_a, 1'b0);
        repeat (2) @(negedge clk);
        chk("abort_c14_tx_ready", tx_ready_a, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        chk("abort_reenable_ready", tx_ready_a, 1'b1);
        chk("abort_reenable_busy", busy_a, 1'b0);

        // Measurement: 4 edges per 16-cycle window
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (meas_valid_a) found = 1'b1;
        end
        chk("meas_first_pulse_seen", found, 1'b1);
        for (int r = 0; r < 3; r++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!meas_valid_a && n < 40);
            chk($sformatf("meas_period_%0d", r), n, 16);
            chk($sformatf("meas_count_%0d", r), meas_count_a, 20'd4);
        end

        // Display of 4 on instance A: 04 for 4 cycles, then 00 for 12
        found = 1'b0;
        prev  = leds_a;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (leds_a == 8'h04 && prev != 8'h04) found = 1'b1;
            else prev = leds_a;
        end
        chk("disp_a_slot0_seen", found, 1'b1);
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("disp_a_c%0d", c), leds_a, (c < 4) ? 8'h04 : 8'h00);
            @(negedge clk);
        end

        // Saturation on instance B (CNT_W=9, max edge rate, WINDOW=1024)
        for (int r = 0; r < 2; r++) begin
            found = 1'b0;
            for (int c = 0; c < 1100 && !found; c++) begin
                @(negedge clk);
                if (meas_valid_b) found = 1'b1;
            end
            chk($sformatf("sat_pulse_%0d_seen", r), found, 1'b1);
        end
        chk("sat_meas_count", meas_count_b, 9'd511);

        // Display of 511 on instance B: FF for 4 cycles, then 01 for 4
        found = 1'b0;
        prev  = leds_b;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (leds_b == 8'hFF && prev != 8'hFF) found = 1'b1;
            else prev = leds_b;
        end
        chk("disp_b_slot0_seen", found, 1'b1);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("disp_b_c%0d", c), leds_b, (c < 4) ? 8'hFF : 8'h01);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a frame
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid_busy_before_reset", busy_a, 1'b1);
        chk("mid_meas_before_reset", meas_count_a, 20'd4);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_heat_on", heat_on_a, 1'b0);
        chk("mid_rst_heater", heater_a, 6'h00);
        chk("mid_rst_tx_ready", tx_ready_a, 1'b0);
        chk("mid_rst_meas_count", meas_count_a, 20'h0);
        chk("mid_rst_meas_valid", meas_valid_a, 1'b0);
        chk("mid_rst_leds", leds_a, 8'h00);
        chk("mid_rst_meas_count_b", meas_count_b, 9'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/thermal_link_ctrl.md
Name: thermal_link_ctrl

Overview:
Parametrised thermal covert-channel transceiver core. The transmit side takes a data word over a valid/ready handshake and frames it as on/off keying of NUM_BANKS toggling heater banks, one bit per BIT_PERIOD cycles. The receive side counts rising edges of an external ring-oscillator input over a fixed window, and time-multiplexes the count onto 8 LEDs. It supersedes the single-bank, free-running heater/counter design.

Parameters:
NUM_BANKS, 4, number of independent heater banks
HEATER_W, 75, toggle flops per bank
DATA_W, 8, payload bits per frame (1..32)
BIT_PERIOD, 1000000, clk cycles per transmitted bit (>=2)
WINDOW, 65536, clk cycles per measurement window (>=2)
CNT_W, 20, measurement count width (9..32)
DISP_SHIFT, 17, LED byte slot lasts 2^DISP_SHIFT cycles

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  transmitter enable
tx_data  in  DATA_W  payload, sampled on handshake
tx_valid  in  1  payload valid
tx_ready  out  1  transmitter can accept a payload
busy  out  1  frame in progress
heat_on  out  1  current keyed bit (1 = heating)
heater  out  NUM_BANKS*HEATER_W  heater toggle flops (keep attribute applied)
ro_in  in  1  asynchronous ring-oscillator sense input
meas_count  out  CNT_W  last completed window edge count
meas_valid  out  1  one-cycle pulse when meas_count updates
leds  out  8  multiplexed display of meas_count

Behaviour:
- Reset: state IDLE; tx_ready, busy, heat_on, heater, meas_count, meas_valid, and leds all 0. Window counter, edge counter, display timer, and synchronisers cleared.
- tx_ready = enable AND state==IDLE (combinational from registered state).
- Handshake: a frame is accepted when tx_valid AND tx_ready at a clk edge; tx_data is latched into a shift register. tx_data is ignored at all other times.
- FSM states:
  - IDLE -> PREAMBLE on accept.
  - PREAMBLE: 8 bits of 8'b10101010, MSB first.
  - DATA: DATA_W bits, LSB first.
  - GUARD: 1 bit period with heat_on=0.
  - GUARD -> IDLE.
- Each bit occupies exactly BIT_PERIOD cycles. A bit-period counter counts 0..BIT_PERIOD-1 and advances the bit at terminal count.
- Cycle timing:
  - The first PREAMBLE bit appears on heat_on in the cycle after accept.
  - Frame length is (8+DATA_W+1)*BIT_PERIOD cycles.
  - tx_ready reasserts in the cycle after the last GUARD cycle.
  - Back-to-back frames are allowed with no gap beyond this.
- busy = 1 in all states except IDLE.
- Heater drive:
  - Each cycle with heat_on=1, every heater bit inverts, with all banks in phase.
  - When heat_on=0, heater is held at all-zero. The clear happens in the first cycle after heat_on falls.
- enable deasserted while busy: the frame aborts. The FSM goes to IDLE on the next edge, heat_on goes to 0, and the heater clears. No partial-frame resume.
- Measurement (independent of enable):
  - ro_in passes through a 2-flop synchroniser followed by a rising-edge detector.
  - The edge counter increments on each detected edge and saturates at 2^CNT_W-1.
  - The window counter runs 0..WINDOW-1 continuously.
  - At terminal count, meas_count takes the edge total including any edge detected that same cycle. meas_valid pulses for 1 cycle, and the edge counter restarts from 0.
- Display:
  - A free-running timer selects a slot = timer[DISP_SHIFT+k-1:DISP_SHIFT], where k = bits needed for NB = ceil(CNT_W/8) slots.
  - Slot i < NB shows byte i of meas_count, LSB byte first. The top byte is zero-padded.
  - Slot values >= NB show 0.
  - leds is registered, with 1 cycle latency from slot change.
- Reset asserted mid-frame or mid-window returns everything to reset values immediately (asynchronously).

Test Plan:
- Params NUM_BANKS=2, HEATER_W=3, DATA_W=8, BIT_PERIOD=4. Send tx_data=8'hA5 with enable=1 -> heat_on sequence per 4 cycles: 1,0,1,0,1,0,1,0, then 1,0,1,0,0,1,0,1, then guard 0. Frame length 68 cycles; tx_ready high again on cycle 69.
- During a heat_on=1 bit: heater alternates 6'b111111/6'b000000 each cycle; heater=0 within 1 cycle of heat_on=0.
- Assert tx_valid while busy with data 8'h3C -> no accept; the current frame is unchanged. Accept occurs only once the frame completes.
- Drop enable at cycle 10 of a frame -> busy=0 and heat_on=0 next cycle; tx_ready stays 0 until enable=1.
- WINDOW=16, ro_in toggling every 2 cycles (period 4) -> meas_count=4 with a meas_valid pulse every 16 cycles. CNT_W=9 with ro_in at max edge rate over WINDOW=1024 -> saturates at 511.
- CNT_W=20, DISP_SHIFT=2, meas_count=20'hABCDE -> leds cycle 8'hDE, 8'hBC, 8'h0A, 8'h00, each held 4 cycles. Reset mid-frame -> all outputs 0.
